// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared constants for the fetch stage and its IF/ID register
package instruction_fetch_pkg;
   localparam logic [1:0] ST_REQ = 2'd0;
   localparam logic [1:0] ST_SQUASH = 2'd1;
   localparam logic [1:0] ST_HOLD = 2'd2;
   localparam logic [31:0] BUBBLE_INSTR_DEF = 32'h0000_0000;
   localparam logic [63:0] PC_INC = 64'd4;
endpackage

// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: req/ready instruction memory bus
interface instruction_fetch_if;
   logic imem_req;
   logic [63:0] imem_addr;
   logic imem_ready;
   logic [31:0] imem_rdata;
   modport master(output imem_req, imem_addr, input imem_ready, imem_rdata);
   modport slave(input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/instruction_fetch_if_id_reg.sv
// instruction_fetch_if_id_reg: IF/ID pipeline register with load, hold and bubble controls
module instruction_fetch_if_id_reg import instruction_fetch_pkg::*; #(
   parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        load,
   input  logic        bubble,
   input  logic [31:0] d_instr,
   input  logic [63:0] d_pc,
   output logic [31:0] instruction,
   output logic [63:0] pc,
   output logic        valid
);
   // bubble wins over load; neither means hold
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         instruction <= BUBBLE_INSTR;
         pc <= '0;
         valid <= 1'b0;
      end else if (bubble) begin
         instruction <= BUBBLE_INSTR;
         pc <= '0;
         valid <= 1'b0;
      end else if (load) begin
         instruction <= d_instr;
         pc <= d_pc;
         valid <= 1'b1;
      end
endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC, imem request FSM, one-word stall buffer and IF/ID register
module instruction_fetch import instruction_fetch_pkg::*; #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] BUBBLE_INSTR = BUBBLE_INSTR_DEF
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       stall,
   input  logic                       or_out,
   input  logic                       Branchreg,
   input  logic [63:0]                PC_CB,
   input  logic [63:0]                read_data1,
   input  logic                       IF_ID_Flush,
   instruction_fetch_if.master        imem,
   output logic [31:0]                instruction,
   output logic [63:0]                PC_out_IF_ID,
   output logic                       if_id_valid
);
   logic [1:0] state;
   logic [63:0] pc, pc_inc, target, redirect_pc, bufpc, d_pc;
   logic [31:0] buffer, d_instr;
   logic redirect, kill, load, bubble;

   assign target = Branchreg ? read_data1 : PC_CB;
   assign redirect = or_out & ~stall;
   assign kill = (or_out | IF_ID_Flush) & ~stall;
   assign pc_inc = pc + PC_INC;
   assign imem.imem_req = state != ST_HOLD;
   assign imem.imem_addr = pc;

   // IF/ID control: load a fresh or buffered word, or inject a bubble; stall holds everything
   always_comb begin
      load = ~stall & ~kill & ((state == ST_REQ & imem.imem_ready) | state == ST_HOLD);
      bubble = ~stall & (state == ST_SQUASH | (state == ST_REQ & (~imem.imem_ready | kill)) | (state == ST_HOLD & kill));
      d_instr = state == ST_HOLD ? buffer : imem.imem_rdata;
      d_pc = state == ST_HOLD ? bufpc : pc;
   end

   // PC, buffer and fetch state; the address only moves when a request completes or in HOLD
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= ST_REQ;
         pc <= RESET_PC;
         buffer <= '0;
         bufpc <= '0;
         redirect_pc <= '0;
      end else
         case (state)
            ST_REQ:
               if (imem.imem_ready) begin
                  if (stall) begin
                     buffer <= imem.imem_rdata;
                     bufpc <= pc;
                     pc <= pc_inc;
                     state <= ST_HOLD;
                  end else if (redirect)
                     pc <= target;
                  else if (!kill)
                     pc <= pc_inc;
               end else if (redirect) begin
                  redirect_pc <= target;
                  state <= ST_SQUASH;
               end
            ST_SQUASH:
               if (imem.imem_ready) begin
                  pc <= redirect ? target : redirect_pc;
                  state <= ST_REQ;
               end else if (redirect)
                  redirect_pc <= target;
            ST_HOLD:
               if (!stall) begin
                  pc <= redirect ? target : kill ? bufpc : pc;
                  state <= ST_REQ;
               end
            default: state <= ST_REQ;
         endcase

   instruction_fetch_if_id_reg #(.BUBBLE_INSTR(BUBBLE_INSTR)) u_if_id (
      .clock(clock),
      .reset(reset),
      .load(load),
      .bubble(bubble),
      .d_instr(d_instr),
      .d_pc(d_pc),
      .instruction(instruction),
      .pc(PC_out_IF_ID),
      .valid(if_id_valid)
   );
endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
IF stage plus IF/ID pipeline register, directly upstream of instruction_decode. Holds the PC and issues requests to a variable-latency instruction memory over a req/ready handshake. Presents `instruction` and `PC_out_IF_ID` to decode. Applies decode's `stall`, redirect (`or_out`, `Branchreg`) and `IF_ID_Flush` controls. Buffers one word fetched during a stall, and squashes an in-flight fetch on redirect.

Parameters:
- RESET_PC, 64'h0: PC value after reset.
- BUBBLE_INSTR, 32'h0000_0000: encoding injected as a bubble; control decodes it to all-zero controls.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- stall  in  1  load-use stall from hazard unit; hold PC and IF/ID
- or_out  in  1  branch taken (from decode)
- Branchreg  in  1  taken branch uses register target (BR)
- PC_CB  in  64  PC-relative branch target (from decode)
- read_data1  in  64  register branch target (from decode)
- IF_ID_Flush  in  1  replace IF/ID contents with a bubble
- imem_req  out  1  fetch request
- imem_addr  out  64  fetch address; stable while imem_req is high
- imem_ready  in  1  imem_rdata valid this cycle; completes the request
- imem_rdata  in  32  fetched word
- instruction  out  32  IF/ID instruction
- PC_out_IF_ID  out  64  IF/ID PC of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction, not a bubble

Behaviour:
- Reset (async) values:
  - PC = RESET_PC, state = REQ.
  - instruction = BUBBLE_INSTR, PC_out_IF_ID = 0, if_id_valid = 0.
  - buffer = 0, redirect_pc = 0.
  - imem_req = 1 in REQ.
- Definitions:
  - target = Branchreg ? read_data1 : PC_CB.
  - redirect = or_out & ~stall.
  - kill = (or_out | IF_ID_Flush) & ~stall.
  - Stall has priority: when stall=1, redirect and kill are ignored; the hazard unit guarantees decode's controls are zeroed then.
- imem_addr = PC in REQ and SQUASH. imem_req = 1 in REQ and SQUASH, 0 in HOLD.
- REQ state:
  - ready & ~stall & ~redirect & ~kill: IF/ID <= {rdata, PC, valid=1}; PC <= PC+4; stay REQ. Zero-wait memory gives one instruction per cycle.
  - ready & stall: buffer <= rdata, bufpc <= PC; PC <= PC+4; IF/ID held; go HOLD.
  - ready & redirect: discard rdata; PC <= target; IF/ID <= bubble; stay REQ.
  - ~ready & redirect: redirect_pc <= target; IF/ID <= bubble; go SQUASH. PC is unchanged so the address stays stable.
  - ~ready & ~stall & ~redirect: IF/ID <= bubble (valid=0); stay REQ.
  - ~ready & stall: IF/ID held; stay REQ.
  - kill without redirect (IF_ID_Flush alone): IF/ID <= bubble and the fetched word is discarded; PC unchanged.
- SQUASH state:
  - Fetch still outstanding; IF/ID <= bubble each unstalled cycle.
  - redirect: redirect_pc <= target (latest wins).
  - ready: discard rdata; PC <= redirect_pc, or target if redirect in the same cycle; go REQ.
- HOLD state:
  - stall: everything held.
  - ~stall & redirect: drop buffer; PC <= target; IF/ID <= bubble; go REQ.
  - ~stall & kill only: drop buffer; PC <= bufpc; IF/ID <= bubble; go REQ. The word is refetched.
  - ~stall otherwise: IF/ID <= {buffer, bufpc, valid=1}; go REQ.
- Arithmetic: PC+4 is 64-bit modular and wraps at 2^64. Targets are used verbatim; PC[1:0] is not checked.
- Reset mid-fetch: the outstanding response is ignored by construction. The memory must drop a pending request on reset.

Decomposition:
- Shared package: state encoding (REQ, SQUASH, HOLD), BUBBLE_INSTR default, PC_INC = 4.
- One sub-module is natural: if_id_reg. It holds instruction, PC_out_IF_ID and if_id_valid, with load/hold/bubble controls.
- Next-PC muxing uses the existing n_mux. PC+4 uses the existing alu_add.

Test Plan:
1. Zero-wait memory with rdata = address, reset, 4 cycles → imem_addr 0,4,8,12; PC_out_IF_ID 0,4,8 one cycle later; if_id_valid = 1.
2. Stall for 2 cycles while ready=1 at PC=8 → IF/ID holds PC 4; imem_req = 0 during HOLD; after release IF/ID = {word@8, 8}, then imem_addr = 12.
3. or_out=1, Branchreg=0, PC_CB=0x100 with ready=1 → next imem_addr = 0x100; IF/ID bubble (valid 0, instr 0); the 0x100 word reaches IF/ID one cycle later.
4. ready delayed 3 cycles at PC=0x20; or_out with Branchreg=1, read_data1=0x400 in wait cycle 1 → imem_addr stays 0x20 until ready; the 0x20 word is discarded; next request is 0x400; no valid 0x24.
5. IF_ID_Flush alone during HOLD (bufpc=0x30) → bubble; next imem_addr = 0x30.
6. Assert reset mid-SQUASH → outputs return to reset values immediately; first request is RESET_PC.
